// File: rtl/tank_motion_ctrl_if.sv
// Candidate-position handshake between the motion sequencer and the maze wall checker.
interface tank_motion_ctrl_if;
  logic [9:0] cand_x;
  logic [9:0] cand_y;
  logic       cand_valid;
  logic       wall_ready;
  logic       wall_hit;

  modport master (output cand_x, cand_y, cand_valid, input wall_ready, wall_hit);
  modport slave  (input cand_x, cand_y, cand_valid, output wall_ready, wall_hit);
endinterface

// File: rtl/tank_motion_ctrl.sv
// Per-tank motion sequencer: steps the heading, integrates a 10.8 fixed-point position
// once per frame and offers every candidate to the wall checker before committing it.
module tank_motion_ctrl #(
  parameter int X_INIT       = 320,
  parameter int Y_INIT       = 240,
  parameter int ANG_INIT     = 0,
  parameter int ROT_DIV      = 4,
  parameter int SPEED_SHIFT  = 0,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int WALL_TIMEOUT = 15
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               key_fwd,
  input  logic               key_back,
  input  logic [8:0]         sin_mag,
  input  logic [8:0]         cos_mag,
  output logic [5:0]         angle_idx,
  tank_motion_ctrl_if.master wallBus,
  output logic [9:0]         pos_x,
  output logic [9:0]         pos_y,
  output logic               busy
);
  localparam int ROT_W  = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
  localparam int WAIT_W = (WALL_TIMEOUT > 1) ? $clog2(WALL_TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, ROTATE, LOOKUP, MOVE, WALLCHK, COMMIT} stateType;

  stateType          stateReg, stateNext;
  logic [5:0]        angleReg, angleNext;
  logic [ROT_W-1:0]  rotCntReg, rotCntNext;
  logic [WAIT_W-1:0] waitReg, waitNext;
  // Element 0 is the X axis (driven by cos), element 1 the Y axis (driven by sin).
  logic [1:0][8:0]   magReg, magNext;
  logic [1:0][17:0]  posReg, posNext;
  logic [1:0][17:0]  candReg, candNext;
  logic [1:0][17:0]  candCalc;
  logic [1:0]        negAxis;
  logic              cosNeg, sinNeg;

  function automatic logic [17:0] stepAxis(input logic [17:0] pos, input logic [8:0] mag,
                                           input logic neg, input logic [17:0] lim);
    logic signed [20:0] step;
    logic signed [20:0] sum;
    step = signed'(21'(mag) << SPEED_SHIFT);
    sum  = neg ? signed'({3'b000, pos}) - step : signed'({3'b000, pos}) + step;
    if (sum < 0)
      return '0;
    if (sum > signed'({3'b000, lim}))
      return lim;
    return sum[17:0];
  endfunction

  assign cosNeg = (angleReg >= 6'd12) && (angleReg <= 6'd33);
  assign sinNeg = (angleReg >= 6'd23);
  // Screen Y grows downward, so a positive sine moves the tank toward smaller Y.
  assign negAxis[0] = key_back ^ cosNeg;
  assign negAxis[1] = ~(key_back ^ sinNeg);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gAxis
      localparam logic [17:0] AXIS_LIM = (gi == 0) ? 18'((X_MAX << 8) | 255)
                                                   : 18'((Y_MAX << 8) | 255);
      assign candCalc[gi] = stepAxis(posReg[gi], magReg[gi], negAxis[gi], AXIS_LIM);
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (!Reset)
      stateReg <= IDLE;
    else
      stateReg <= stateNext;
  end

  always_comb begin
    stateNext  = stateReg;
    angleNext  = angleReg;
    rotCntNext = rotCntReg;
    waitNext   = waitReg;
    magNext    = magReg;
    posNext    = posReg;
    candNext   = candReg;
    case (stateReg)
      IDLE: begin
        if (frame_tick)
          stateNext = ROTATE;
      end
      ROTATE: begin
        if (key_left ^ key_right) begin
          if (rotCntReg == '0) begin
            if (key_left)
              angleNext = (angleReg == 6'd44) ? 6'd0 : angleReg + 6'd1;
            else
              angleNext = (angleReg == 6'd0) ? 6'd44 : angleReg - 6'd1;
          end
          rotCntNext = (rotCntReg == ROT_W'(ROT_DIV - 1)) ? '0 : rotCntReg + 1'b1;
        end else begin
          rotCntNext = '0;
        end
        stateNext = LOOKUP;
      end
      LOOKUP: begin
        magNext[0] = cos_mag;
        magNext[1] = sin_mag;
        stateNext  = MOVE;
      end
      MOVE: begin
        if (key_fwd ^ key_back) begin
          candNext  = candCalc;
          waitNext  = '0;
          stateNext = WALLCHK;
        end else begin
          stateNext = IDLE;
        end
      end
      WALLCHK: begin
        // A response arriving on the last allowed cycle still wins over the timeout.
        if (wallBus.wall_ready)
          stateNext = wallBus.wall_hit ? IDLE : COMMIT;
        else if (waitReg == WAIT_W'(WALL_TIMEOUT - 1))
          stateNext = IDLE;
        else
          waitNext = waitReg + 1'b1;
      end
      COMMIT: begin
        posNext   = candReg;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      angleReg  <= 6'(ANG_INIT);
      rotCntReg <= '0;
      waitReg   <= '0;
      magReg    <= '0;
      posReg    <= {18'(Y_INIT * 256), 18'(X_INIT * 256)};
      candReg   <= '0;
    end else begin
      angleReg  <= angleNext;
      rotCntReg <= rotCntNext;
      waitReg   <= waitNext;
      magReg    <= magNext;
      posReg    <= posNext;
      candReg   <= candNext;
    end
  end

  assign angle_idx          = angleReg;
  assign pos_x              = posReg[0][17:8];
  assign pos_y              = posReg[1][17:8];
  assign wallBus.cand_x     = candReg[0][17:8];
  assign wallBus.cand_y     = candReg[1][17:8];
  assign wallBus.cand_valid = (stateReg == WALLCHK);
  assign busy               = (stateReg != IDLE);
endmodule
